// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI transmit engine between NREQ requesters.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort frames whose engine never drops busy.

module spi_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic                 spi_start,
    output logic [DW-1:0]        spi_datain,
    input  logic                 spi_busy,
    output logic                 arb_busy,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_XFER,
        S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           winner;
    logic                    any_req;
    logic                    timeout_hit;
    logic [NREQ-1:0][DW-1:0] words;

    assign words = req_data;

    // Scan from farthest to nearest so the first requester after rr_ptr overwrites last.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_p;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        idx_p   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_p = PW'(idx);
            if (req[idx_p]) begin
                winner  = idx_p;
                any_req = 1'b1;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_exit;
    logic          err_q;

    // Counts cycles since the launch cycle; held at zero while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               tmo_cnt <= '0;
        else if (state == S_IDLE) tmo_cnt <= '0;
        else                      tmo_cnt <= tmo_cnt + CW'(1);
    end

    assign timeout_hit = (tmo_cnt == CW'(TIMEOUT - 1));
    // A real busy fall in XFER wins over a coincident timeout.
    assign tmo_exit    = timeout_hit &&
                         ((state == S_WAIT_BUSY) || (state == S_XFER && spi_busy));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= tmo_exit;
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        arb_busy  = 1'b1;
        ack       = '0;
        case (state)
            S_IDLE: begin
                arb_busy = 1'b0;
                if (any_req) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                spi_start = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (timeout_hit)   state_nxt = S_DONE;
                else if (spi_busy) state_nxt = S_XFER;
            end
            S_XFER: begin
                if (!spi_busy || timeout_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                ack       = grant;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Winner's word is captured at grant; later req_data changes cannot reach the engine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= '0;
            spi_datain <= '0;
            rr_ptr     <= PW'(NREQ - 1);
        end else if (state == S_IDLE && any_req) begin
            grant      <= NREQ'(1) << winner;
            spi_datain <= words[winner];
            rr_ptr     <= winner;
        end else if (state == S_DONE) begin
            grant      <= '0;
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomized self-checking bench for spi_tx_arbiter with a behavioural SPI engine
// and a rotation model of the round-robin service order.

module tb_spi_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     ack;
    logic                spi_start;
    logic [DW-1:0]       spi_datain;
    logic                spi_busy = 1'b0;
    logic                arb_busy;
    logic                err;

    int checks = 0;
    int errors = 0;

    int   busy_len = 32;
    int   bcnt = 0;
    logic eng_abort = 1'b0;
    int   rr_last = NREQ - 1;
    logic [DW-1:0] words [NREQ];

    spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .ack        (ack),
        .spi_start  (spi_start),
        .spi_datain (spi_datain),
        .spi_busy   (spi_busy),
        .arb_busy   (arb_busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Engine: busy rises the edge after it sees spi_start and stays high busy_len cycles.
    always @(posedge clk) begin
        if (eng_abort) begin
            spi_busy <= 1'b0;
            bcnt     <= 0;
        end else if (spi_start) begin
            spi_busy <= 1'b1;
            bcnt     <= busy_len;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) spi_busy <= 1'b0;
        end
    end

    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(rr_last + k) % NREQ]) return (rr_last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_words();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = words[i];
    endtask

    task automatic do_reset();
        req       = '0;
        reset     = 1'b0;
        eng_abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        eng_abort = 1'b0;
        rr_last   = NREQ - 1;
    endtask

    task automatic wait_start(input int limit, output int cyc);
        cyc = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (spi_start) begin cyc = n; break; end
        end
    endtask

    task automatic wait_ack(input int limit, output int cyc);
        cyc = -1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (ack != '0) begin cyc = n; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        @(posedge clk); #1;
        checks++;
        if ({grant, ack, spi_start, spi_datain, arb_busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b ack=%b start=%b data=%0d busy=%b err=%b, all must be 0",
                     grant, ack, spi_start, spi_datain, arb_busy, err);
        end
    endtask

    task automatic test_single();
        int c;
        do_reset();
        busy_len = 32;
        for (int i = 0; i < NREQ; i++) words[i] = DW'($urandom);
        words[0] = 16'd2679;
        drive_words();
        req = 4'b0001;
        wait_start(5, c);
        checks++;
        if (c !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", c); end
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", grant); end
        checks++;
        if (spi_datain !== 16'd2679) begin errors++; $display("FAIL single_data: got %0d want 2679", spi_datain); end
        checks++;
        if (arb_busy !== 1'b1) begin errors++; $display("FAIL single_arb_busy: got %b want 1", arb_busy); end
        wait_ack(100, c);
        checks++;
        if (c !== busy_len + 2) begin errors++; $display("FAIL single_ack_time: got %0d want %0d", c, busy_len + 2); end
        checks++;
        if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
        req = '0;
        @(posedge clk); #1;
        checks++;
        if ({ack, grant, arb_busy} !== '0) begin
            errors++;
            $display("FAIL single_idle: ack=%b grant=%b arb_busy=%b want all 0", ack, grant, arb_busy);
        end
    endtask

    task automatic test_round_robin();
        int c, w;
        logic [NREQ-1:0] exp_g;
        do_reset();
        busy_len = 32;
        words[0] = 16'd6876; words[1] = 16'd6968; words[2] = 16'd9800; words[3] = 16'd9975;
        drive_words();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_start(5, c);
            w = model_pick(req);
            exp_g = '0;
            exp_g[w] = 1'b1;
            checks++;
            if (c !== 1 || grant !== exp_g) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got grant=%b after %0d cycles want %b after 1", f, grant, c, exp_g);
            end
            checks++;
            if (spi_datain !== words[w]) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %0d want %0d", f, spi_datain, words[w]);
            end
            wait_ack(100, c);
            checks++;
            if (ack !== exp_g) begin errors++; $display("FAIL rr_ack[%0d]: got %b want %b", f, ack, exp_g); end
            rr_last = w;
            if (f == 4) req = '0;
            @(posedge clk); #1;
            checks++;
            if (ack !== '0 || arb_busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_single_pulse[%0d]: ack=%b arb_busy=%b want 0/0", f, ack, arb_busy);
            end
        end
    endtask

    task automatic test_data_capture();
        int c;
        bit bad;
        do_reset();
        busy_len = 32;
        words[1] = 16'd6876;
        drive_words();
        req = 4'b0010;
        wait_start(5, c);
        checks++;
        if (grant !== 4'b0010) begin errors++; $display("FAIL capture_grant: got %b want 0010", grant); end
        repeat (4) @(posedge clk);
        #1;
        req_data[31:16] = '0;
        bad = 1'b0;
        c   = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (spi_datain !== 16'd6876) bad = 1'b1;
            if (ack != '0) begin c = n; break; end
        end
        checks++;
        if (bad || c < 0) begin
            errors++;
            $display("FAIL capture_hold: data=%0d ack_cycle=%0d want 6876 held until ack", spi_datain, c);
        end
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int c;
        bit saw_ack;
        do_reset();
        busy_len = 32;
        for (int i = 0; i < NREQ; i++) words[i] = DW'($urandom);
        drive_words();
        req = 4'b0001;
        wait_start(5, c);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({grant, ack, spi_start, spi_datain, arb_busy, err} !== '0) begin
            errors++;
            $display("FAIL midreset_async: grant=%b ack=%b start=%b data=%0d busy=%b err=%b, all must be 0",
                     grant, ack, spi_start, spi_datain, arb_busy, err);
        end
        saw_ack = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack != '0) saw_ack = 1'b1;
        end
        checks++;
        if (saw_ack) begin errors++; $display("FAIL midreset_no_ack: got an ack pulse, want none"); end
        // Pointer must be back at NREQ-1: with 0 and 1 pending, 0 is served first.
        req = 4'b0011;
        reset = 1'b1;
        rr_last = NREQ - 1;
        wait_start(5, c);
        checks++;
        if (c !== 1 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_first: got grant=%b after %0d cycles want 0001 after 1", grant, c);
        end
        wait_ack(100, c);
        req = 4'b0010;
        rr_last = 0;
        wait_start(5, c);
        checks++;
        if (grant !== 4'b0010 || spi_datain !== words[1]) begin
            errors++;
            $display("FAIL midreset_second: got grant=%b data=%0d want 0010 data=%0d", grant, spi_datain, words[1]);
        end
        wait_ack(100, c);
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int c, w;
        logic [NREQ-1:0] mask, nw, exp_g;
        logic [DW-1:0] cap;
        do_reset();
        for (int i = 0; i < NREQ; i++) words[i] = DW'($urandom);
        mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        drive_words();
        req = mask;
        for (int f = 0; f < 30; f++) begin
            busy_len = $urandom_range(1, 12);
            wait_start(5, c);
            w = model_pick(mask);
            exp_g = '0;
            exp_g[w] = 1'b1;
            cap = words[w];
            checks++;
            if (c !== 1 || grant !== exp_g || spi_datain !== cap) begin
                errors++;
                $display("FAIL rand_start[%0d]: grant=%b data=%0d cyc=%0d want %b data=%0d cyc=1",
                         f, grant, spi_datain, c, exp_g, cap);
            end
            req_data[w*DW +: DW] = ~cap;
            wait_ack(40, c);
            checks++;
            if (c !== busy_len + 2 || ack !== exp_g || err !== 1'b0 || spi_datain !== cap) begin
                errors++;
                $display("FAIL rand_done[%0d]: ack=%b err=%b data=%0d cyc=%0d want %b 0 %0d cyc=%0d",
                         f, ack, err, spi_datain, c, exp_g, cap, busy_len + 2);
            end
            rr_last = w;
            mask[w] = 1'b0;
            nw = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (nw[i] && !mask[i]) begin
                    mask[i]  = 1'b1;
                    words[i] = DW'($urandom);
                end
            end
            if (mask == '0) begin
                c = $urandom_range(0, NREQ - 1);
                mask[c]  = 1'b1;
                words[c] = DW'($urandom);
            end
            if (f == 29) mask = '0;
            drive_words();
            req = mask;
            @(posedge clk); #1;
            checks++;
            if (ack !== '0 || arb_busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_idle[%0d]: ack=%b arb_busy=%b want 0/0", f, ack, arb_busy);
            end
        end
    endtask

    task automatic test_stuck();
        int c;
        do_reset();
        busy_len = 100000;
        for (int i = 0; i < NREQ; i++) words[i] = DW'($urandom);
        drive_words();
        req = 4'b0001;
        wait_start(5, c);
`ifdef SPI_ARB_TIMEOUT_EN
        wait_ack(200, c);
        checks++;
        if (c !== TIMEOUT || ack !== 4'b0001 || err !== 1'b1) begin
            errors++;
            $display("FAIL stuck_timeout: ack=%b err=%b after %0d cycles want 0001/1 after %0d",
                     ack, err, c, TIMEOUT);
        end
        req = '0;
        @(posedge clk); #1;
        checks++;
        if (arb_busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_idle: arb_busy=%b err=%b want 0/0", arb_busy, err);
        end
        eng_abort = 1'b1;
        @(posedge clk); #1;
        eng_abort = 1'b0;
`else
        begin
            bit saw_ack, saw_err, lost_busy;
            saw_ack = 1'b0; saw_err = 1'b0; lost_busy = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(posedge clk); #1;
                if (ack != '0) saw_ack = 1'b1;
                if (err) saw_err = 1'b1;
                if (!arb_busy) lost_busy = 1'b1;
            end
            checks++;
            if (saw_ack || saw_err || lost_busy) begin
                errors++;
                $display("FAIL stuck_wait: saw_ack=%b saw_err=%b lost_busy=%b want 0/0/0",
                         saw_ack, saw_err, lost_busy);
            end
        end
        eng_abort = 1'b1;
        @(posedge clk); #1;
        eng_abort = 1'b0;
        wait_ack(5, c);
        checks++;
        if (c !== 1 || ack !== 4'b0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL stuck_release: ack=%b err=%b cyc=%0d want 0001/0 cyc=1", ack, err, c);
        end
        req = '0;
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_data_capture();
        test_mid_reset();
        test_random();
        test_stuck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
